// File: rtl/fifo_ctrl.sv
// Pointer/status controller that runs an external register file as a circular FIFO.
// Define FIFO_CTRL_ERR_FLAGS_EN to add sticky overflow/underflow flags with err_clr.
module fifo_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int AF_MARGIN  = 1,
  parameter int AE_MARGIN  = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr,
  input  logic                  rd,
`ifdef FIFO_CTRL_ERR_FLAGS_EN
  input  logic                  err_clr,
  output logic                  overflow,
  output logic                  underflow,
`endif
  output logic                  w_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_TH   = (ADDR_WIDTH+1)'(DEPTH - AF_MARGIN);
  localparam logic [ADDR_WIDTH:0] AE_TH   = (ADDR_WIDTH+1)'(AE_MARGIN);
  localparam logic                AF_RST  = (AF_MARGIN >= DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  af_q, af_d;
  logic                  ae_q, ae_d;
  logic                  wr_acc, rd_acc;

  assign wr_acc = wr & ~full_q;
  assign rd_acc = rd & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    full_d   = full_q;
    empty_d  = empty_q;
    unique case ({wr_acc, rd_acc})
      2'b10: begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        level_d  = level_q + 1'b1;
        empty_d  = 1'b0;
        full_d   = ((level_q + 1'b1) == DEPTH_L);
      end
      2'b01: begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        level_d  = level_q - 1'b1;
        full_d   = 1'b0;
        empty_d  = ((level_q - 1'b1) == '0);
      end
      2'b11: begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      default: ;
    endcase
    // Threshold flags come from next-state level so they line up with level.
    af_d = (level_d >= AF_TH);
    ae_d = (level_d <= AE_TH);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= AF_RST;
      ae_q     <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
    end
  end

`ifdef FIFO_CTRL_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  // Set beats err_clr when both occur in the same cycle.
  assign ovf_d = (wr & full_q)  | (ovf_q & ~err_clr);
  assign udf_d = (rd & empty_q) | (udf_q & ~err_clr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = udf_q;
`endif

  assign w_en         = wr_acc;
  assign w_addr       = wr_ptr_q;
  assign r_addr       = rd_ptr_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign level        = level_q;

  a_full_inv: assert property (@(posedge clk) disable iff (!reset_n)
    full_q |-> (level_q == DEPTH_L && wr_ptr_q == rd_ptr_q));
  a_empty_inv: assert property (@(posedge clk) disable iff (!reset_n)
    empty_q |-> (level_q == '0 && wr_ptr_q == rd_ptr_q));
  a_excl: assert property (@(posedge clk) disable iff (!reset_n)
    !(full_q && empty_q));
  a_level_ptr: assert property (@(posedge clk) disable iff (!reset_n)
    !full_q |-> (level_q[ADDR_WIDTH-1:0] == ADDR_WIDTH'(wr_ptr_q - rd_ptr_q)));

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl: models the falling-edge register file and scores FWFT read data.
module tb_fifo_ctrl;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AFM   = 1;
  localparam int AEM   = 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          wr, rd;
  logic          w_en, full, empty, almost_full, almost_empty;
  logic [AW-1:0] w_addr, r_addr;
  logic [AW:0]   level;
  logic [7:0]    w_data;
  logic [7:0]    mem [DEPTH];
  logic [7:0]    r_data;
`ifdef FIFO_CTRL_ERR_FLAGS_EN
  logic          err_clr, overflow, underflow;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0]    sb [$];
  int            m_level;
  logic [AW-1:0] m_wp, m_rp;

  fifo_ctrl #(.ADDR_WIDTH(AW), .AF_MARGIN(AFM), .AE_MARGIN(AEM)) dut (
    .clk(clk), .reset_n(reset_n), .wr(wr), .rd(rd),
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    .err_clr(err_clr), .overflow(overflow), .underflow(underflow),
`endif
    .w_en(w_en), .w_addr(w_addr), .r_addr(r_addr), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .level(level)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (w_en) mem[w_addr] <= w_data;
  assign r_data = mem[r_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    check("level", 32'(level), 32'(m_level));
    check("full", 32'(full), 32'(m_level == DEPTH));
    check("empty", 32'(empty), 32'(m_level == 0));
    check("almost_full", 32'(almost_full), 32'(m_level >= DEPTH - AFM));
    check("almost_empty", 32'(almost_empty), 32'(m_level <= AEM));
    check("w_addr", 32'(w_addr), 32'(m_wp));
    check("r_addr", 32'(r_addr), 32'(m_rp));
  endtask

  // One cycle of stimulus, entered #1 after a rising edge and left #1 after the next.
  task automatic cyc(input logic w, input logic r, input logic [7:0] d);
    logic wacc, racc;
    wr = w; rd = r; w_data = d;
    #1;
    wacc = w && (m_level != DEPTH);
    racc = r && (m_level != 0);
    check("w_en", 32'(w_en), 32'(wacc));
    if (racc) check("r_data", 32'(r_data), 32'(sb.pop_front()));
    if (wacc) sb.push_back(d);
    if (wacc) m_wp = m_wp + 1'b1;
    if (racc) m_rp = m_rp + 1'b1;
    m_level = m_level + int'(wacc) - int'(racc);
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0;
    check_state();
  endtask

  task automatic model_reset();
    m_level = 0; m_wp = '0; m_rp = '0;
    sb.delete();
  endtask

  initial begin
    reset_n = 1'b0; wr = 1'b0; rd = 1'b0; w_data = '0;
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    err_clr = 1'b0;
`endif
    model_reset();
    #12;
    check_state();
    check("w_en_idle", 32'(w_en), 32'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    cyc(1'b0, 1'b0, 8'h00);

    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 8'hA0 + 8'(i));
    check("full_after_8", 32'(full), 32'h1);
    cyc(1'b1, 1'b0, 8'hFF);
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    check("overflow", 32'(overflow), 32'h1);
`endif

    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b1, 8'h00);
    check("empty_after_8", 32'(empty), 32'h1);
    cyc(1'b0, 1'b1, 8'h00);
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    check("underflow", 32'(underflow), 32'h1);
    err_clr = 1'b1;
    cyc(1'b0, 1'b0, 8'h00);
    err_clr = 1'b0;
    check("overflow_clr", 32'(overflow), 32'h0);
    check("underflow_clr", 32'(underflow), 32'h0);
`endif

    // Wrap-around: pointers start at 0 after the full drain above.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'hB0 + 8'(i));
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'h00);
    check("wrap_start_addr", 32'(w_addr), 32'h5);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 8'hC0 + 8'(i));
    check("wrap_level", 32'(level), 32'h6);
    check("wrap_w_addr", 32'(w_addr), 32'h3);

    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b1, 1'b1, 8'hD0);
    check("simul_lvl3", 32'(level), 32'h3);

    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b1, 1'b1, 8'hD1);
    check("simul_empty", 32'(level), 32'h1);

    for (int i = 0; i < DEPTH - 1; i++) cyc(1'b1, 1'b0, 8'hE0 + 8'(i));
    cyc(1'b1, 1'b1, 8'hEE);
    check("simul_full", 32'(level), 32'h7);

    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'h00);
    check("pre_reset_lvl", 32'(level), 32'h4);
    wr = 1'b1; w_data = 8'h55;
    #2;
    reset_n = 1'b0;
    #1;
    wr = 1'b0;
    model_reset();
    check_state();
    #3;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_state();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'h60 + 8'(i));
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'h00);
    check("resume_empty", 32'(empty), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Pointer and status controller that sequences REG_FILE as a circular FIFO buffer, for example the UART RX and TX buffers.
- Converts consumer/producer strobes (rd, wr) into w_en, w_addr and r_addr for the register file.
- Maintains full, empty, almost-full, almost-empty and occupancy level.
- The register file writes on the falling edge of clk and reads combinationally. This block updates all state on the rising edge.

Parameters:
- ADDR_WIDTH, 3, register file address width; DEPTH = 2**ADDR_WIDTH entries.
- AF_MARGIN, 1, almost_full asserts when level >= DEPTH - AF_MARGIN; legal range 0..DEPTH-1.
- AE_MARGIN, 1, almost_empty asserts when level <= AE_MARGIN; legal range 0..DEPTH-1.

Ports:
- clk  input  1  system clock, rising-edge state update.
- reset_n  input  1  asynchronous active-low reset.
- wr  input  1  producer write request, one entry per cycle high.
- rd  input  1  consumer read/pop request, one entry per cycle high.
- w_en  output  1  register file write enable, combinational = wr & ~full.
- w_addr  output  ADDR_WIDTH  register file write address = write pointer.
- r_addr  output  ADDR_WIDTH  register file read address = read pointer.
- full  output  1  DEPTH entries held.
- empty  output  1  zero entries held.
- almost_full  output  1  level threshold flag, registered.
- almost_empty  output  1  level threshold flag, registered.
- level  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset values:
  - wr_ptr = 0, rd_ptr = 0, level = 0.
  - empty = 1, full = 0, almost_empty = 1.
  - almost_full = (0 >= DEPTH - AF_MARGIN), which is 0 for legal margins.
- Reset mid-operation discards all contents immediately; pointers return to 0 asynchronously. Register file contents are not cleared and are don't-care.
- Accept rules, evaluated on the current registered flags:
  - wr_acc = wr & ~full.
  - rd_acc = rd & ~empty.
  - Rejected requests are dropped, with no state change for that side.
- Read data: r_data from REG_FILE is valid combinationally whenever empty = 0. It shows the head entry, i.e. first-word-fall-through. rd pops the head at the next rising edge.
- Write timing: with wr_acc in cycle N, the register file captures w_data at the falling edge inside cycle N. wr_ptr advances at the rising edge ending cycle N.
- State update at the rising edge, by {wr_acc, rd_acc}:
  - 00: hold.
  - 10: wr_ptr+1; level+1; empty <= 0; full <= (level+1 == DEPTH).
  - 01: rd_ptr+1; level-1; full <= 0; empty <= (level-1 == 0).
  - 11: both pointers +1; level, full and empty unchanged.
- Pointer arithmetic: pointers are ADDR_WIDTH bits and wrap DEPTH-1 -> 0 naturally. level is computed exactly with no wrap.
- Simultaneous events:
  - Empty with wr & rd: only the write is accepted. Next cycle empty = 0, level = 1.
  - Full with wr & rd: only the read is accepted. Next cycle full = 0, level = DEPTH-1. This prevents overwriting the head slot before the consumer samples it.
- Flag timing: almost_full and almost_empty are registered from the next-state level, so they are valid in the same cycle as level.
- Invariants to assert:
  - full -> level == DEPTH and wr_ptr == rd_ptr.
  - empty -> level == 0 and wr_ptr == rd_ptr.
  - full & empty is never true.
  - level == (wr_ptr - rd_ptr) mod DEPTH, unless full.

Optional Feature:
- Macro: FIFO_CTRL_ERR_FLAGS_EN.
- Defined:
  - Adds input err_clr (1 bit) and outputs overflow and underflow (1 bit each), all sticky and registered.
  - overflow sets on wr & full. underflow sets on rd & empty.
  - Both clear to 0 on reset and on err_clr.
  - If err_clr and a set condition occur in the same cycle, set wins.
- Undefined: these ports do not exist. Rejected requests are silently dropped with no other change.

Test Plan:
- Reset, then idle -> empty=1, full=0, level=0, almost_empty=1, r_addr=w_addr=0, w_en=0 with wr=0.
- ADDR_WIDTH=3, write 8 values 0xA0..0xA7 back-to-back:
  - level steps 1..8.
  - almost_full rises when level reaches 7.
  - full=1 after the 8th write.
  - A 9th wr gives w_en=0 and no pointer change; overflow=1 if FIFO_CTRL_ERR_FLAGS_EN.
- Drain 8 reads from full -> r_data sequence 0xA0..0xA7, empty=1 after the 8th read. A 9th rd gives no change; underflow=1 if enabled.
- Wrap-around: write 5, read 5, then write 6 -> w_addr goes 5,6,7,0,1,2, level=6, read order preserved.
- Simultaneous wr & rd:
  - At level 3: level stays 3, both pointers +1.
  - When empty: level becomes 1.
  - When full: level becomes 7, w_en=0.
- Assert reset_n low mid-burst at level 4 -> pointers and level become 0 and empty=1 immediately, without a clock edge. Operation resumes normally after release.
